// File: rtl/rr_mux8_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 8-requester round-robin mux arbiter.
package mux8_arb_pkg;

    localparam int N_REQ   = 8;
    localparam int SEL_W   = 3;
    localparam int BURST_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_mux8_arbiter_if.sv
// Requester/arbiter bundle for the shared 8:1 bit-select mux.
interface rr_mux8_arbiter_if;
    import mux8_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] din;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             gnt_valid;
    logic             dout;
    logic             dout_valid;

    modport master (
        output req, din,
        input  gnt, sel, gnt_valid, dout, dout_valid
    );

    modport slave (
        input  req, din,
        output gnt, sel, gnt_valid, dout, dout_valid
    );

endinterface

// File: rtl/rr_mux8_arbiter_pick8.sv
// Rotating priority encoder: first eligible request at or above ptr, wrapping 7->0.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] eligible;
    logic [SEL_W-1:0] cand;

    assign eligible = req & ~mask;

    // Walk from the farthest offset back to ptr so the nearest eligible bit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (eligible[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter driving the shared 8:1 mux select and registering the selected bit.
// Optional per-holder burst limit enabled by defining BURST_LIMIT_EN.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no holder; gnt=0, waiting for any req
//   GRANT | one holder owns the mux; dout tracks din[sel] while held
module rr_mux8_arbiter
    import mux8_arb_pkg::*;
`ifdef BURST_LIMIT_EN
#(
    parameter int MAX_BURST = 4
)
`endif
(
    input  logic                clk,
    input  logic                rst,
    rr_mux8_arbiter_if.slave    bus
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             gv_q, gv_d;
    logic             dout_q, dout_d;
    logic             dv_q, dv_d;
    logic             grant_new;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

`ifdef BURST_LIMIT_EN
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               others_pending;

    assign others_pending = |(bus.req & ~gnt_q);
`endif

    // gnt is zero in IDLE and one-hot(sel) in GRANT, so it doubles as the holder mask.
    rr_pick8 u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .mask  (gnt_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        gv_d      = gv_q;
        dout_d    = dout_q;
        dv_d      = 1'b0;
        grant_new = 1'b0;
`ifdef BURST_LIMIT_EN
        burst_d   = burst_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d   = GRANT;
                    grant_new = 1'b1;
                end
            end
            GRANT: begin
                if (bus.req[sel_q]) begin
                    dout_d = bus.din[sel_q];
                    dv_d   = 1'b1;
`ifdef BURST_LIMIT_EN
                    if (burst_q == BURST_W'(MAX_BURST - 1)) begin
                        burst_d = '0;
                        if (others_pending) begin
                            grant_new = 1'b1;
                        end
                    end else begin
                        burst_d = burst_q + BURST_W'(1);
                    end
`endif
                end else if (pick_found) begin
                    grant_new = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    gv_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant_new) begin
            gnt_d = onehot(pick_idx);
            sel_d = pick_idx;
            gv_d  = 1'b1;
            ptr_d = pick_idx + SEL_W'(1);
`ifdef BURST_LIMIT_EN
            burst_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            gv_q    <= 1'b0;
            dout_q  <= 1'b0;
            dv_q    <= 1'b0;
`ifdef BURST_LIMIT_EN
            burst_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            gv_q    <= gv_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
`ifdef BURST_LIMIT_EN
            burst_q <= burst_d;
`endif
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.sel        = sel_q;
    assign bus.gnt_valid  = gv_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;

endmodule

// File: doc/rr_mux8_arbiter.md
Name: rr_mux8_arbiter

Overview:
- Round-robin arbiter and scheduler for the shared 8:1 bit-select mux datapath.
- Eight requesters compete for the mux. The block grants one requester, drives the 3-bit mux select, and registers the selected data bit.
- Sits between requester logic and the 8:1 mux (4:1 + 4:1 + 2:1 tree). It is the only source of that mux's select lines.

Parameters:
- N_REQ, 8, number of requesters; fixed by the mux width, not to be overridden.
- SEL_W, 3, select width, equal to log2(N_REQ).
- MAX_BURST, 4, maximum consecutive granted cycles per holder; used only when BURST_LIMIT_EN is defined; legal range 1..255.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  per-requester request; held high while the requester wants the mux.
- din  input  8  mux data inputs; bit k belongs to requester k.
- gnt  output 8  one-hot grant, registered; all zero when idle.
- sel  output 3  registered mux select; equals the index of the gnt bit.
- gnt_valid  output 1  high when gnt is nonzero.
- dout  output 1  registered din[sel].
- dout_valid  output 1  dout qualifier.

Behaviour:
- Reset:
  - Clock and reset: one clock; reset is asynchronous and active-high (clk, rst).
  - While rst is high, all outputs are 0, state is IDLE, and the round-robin pointer ptr=0.
  - Reset asserted mid-grant clears everything immediately, with no completion of the burst.
- State machine IDLE / GRANT; ptr is a 3-bit "next preferred index".
- Pick function: search req from index ptr upward, wrapping 7->0. The first set bit wins. found=0 if req==0.
- IDLE:
  - If found, then at the next edge: gnt=onehot(winner), sel=winner, gnt_valid=1, ptr=winner+1 (mod 8), go to GRANT.
  - Arbitration latency is exactly 1 cycle from req sampled to gnt.
- GRANT, while req[sel]=1:
  - Stay in GRANT.
  - Each edge: dout<=din[sel], dout_valid<=1.
- GRANT, when req[sel]=0 is sampled (release):
  - Re-pick in the same edge, starting at ptr (=sel+1).
  - If found: grant moves directly to the new winner with no bubble cycle; ptr updates to winner+1.
  - If not found: gnt=0, sel holds its last value, gnt_valid=0, go to IDLE.
  - dout_valid<=0 on the release edge; dout holds its last value.
- Simultaneous events:
  - A release and a new req on the same edge: the new req is eligible in that pick.
  - A holder that drops and re-raises req on consecutive cycles is re-granted only after the others have had their turn.
- gnt is never multi-hot. sel never changes while gnt_valid=1 and req[sel]=1, except on a burst rotate.
- din changes are not sampled when dout_valid would be 0.

Optional Feature:
- Macro: BURST_LIMIT_EN.
- Defined:
  - An 8-bit burst counter clears on each new grant and increments each GRANT cycle.
  - When count reaches MAX_BURST-1 and any other req bit is set, the next edge forces a rotate: pick from ptr with req[sel] masked, same as a release. dout_valid=1 still applies on that edge.
  - If no other requester is pending, the holder keeps the grant and the counter restarts at 0.
- Undefined: no counter is present; a holder keeps the mux for as long as its req stays high.

Decomposition:
- Package mux8_arb_pkg holds:
  - constants N_REQ=8 and SEL_W=3;
  - the state encoding (IDLE=1'b0, GRANT=1'b1);
  - the burst counter width.
- One natural sub-module, rr_pick8: a purely combinational rotate-and-priority-encode taking (req[7:0], ptr[2:0], mask[7:0]) and returning (found, idx[2:0]).
- The top holds the state machine, ptr, burst counter and output registers.

Test Plan:
1. Assert rst during GRANT with sel=5: gnt=0, sel=0, gnt_valid=0, dout=0 and dout_valid=0 immediately. After release, req=8'h01 gives gnt=8'h01 one edge later.
2. From reset, req=8'h10 and din=8'h10: edge 1 gives gnt=8'h10, sel=4, gnt_valid=1. Edge 2 gives dout=1, dout_valid=1.
3. With ptr=0, req=8'h81: gnt=8'h01. Drop req[0] for one cycle, then re-raise it: gnt=8'h80 with no idle cycle, then 8'h01 after req[7] drops.
4. The holder at sel=2 drops req with no others pending: the next edge gives gnt=0, gnt_valid=0, sel=2 held, dout_valid=0, state IDLE.
5. BURST_LIMIT_EN defined, MAX_BURST=4, req=8'h03 held: gnt sequence is 01 x4, 02 x4, 01 x4. With req=8'h01 only, gnt=01 continuously. Macro undefined: gnt=01 indefinitely.
6. req=8'hFF, each holder releases after 1 cycle: sel sequence is 0,1,2,...,7,0. gnt stays one-hot every cycle (assertion check).
